// File: rtl/rpc_resp_pkg.sv
// Shared types and constants for the RPC command responder.
// Optional page-crossing check is enabled by RPC_RESP_PAGE_CHECK_EN.
package rpc_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_e;

  localparam int ReadFifoDepth  = 2;
  localparam int MemReadLatency = 1;

endpackage

// File: rtl/rpc_resp_rd_fifo.sv
// Two-entry read return FIFO of {last, data}.
// Fall-through when empty so a returning word is visible the same cycle.
module rpc_resp_rd_fifo
  import rpc_resp_pkg::*;
#(
  parameter int Width = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             last_o,
  output logic [1:0]       count_o
);

  logic [Width:0] mem_q [ReadFifoDepth];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     cnt_q;
  logic           empty;
  logic           store;
  logic           drop;

  assign empty   = (cnt_q == 2'd0);
  // A word pushed and popped while empty bypasses storage.
  assign store   = push_i & ~(empty & pop_i);
  assign drop    = pop_i & ~empty;
  assign valid_o = ~empty | push_i;
  assign count_o = cnt_q;

  assign {last_o, data_o} = empty ?
    {push_last_i, push_data_i} : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (store) wr_ptr_q <= ~wr_ptr_q;
      if (drop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, store} - {1'b0, drop};
    end
  end

endmodule

// File: rtl/rpc_cmd_responder.sv
// Device-side command responder executing bursts on a fixed-latency SRAM.
// Define RPC_RESP_PAGE_CHECK_EN to enable the sticky page-crossing flag.
module rpc_cmd_responder
  import rpc_resp_pkg::*;
#(
  parameter int DramAddrWidth = 20,
  parameter int DramLenWidth  = 6,
  parameter int DramDataWidth = 256,
  parameter int MaskWidth     = 32,
  parameter int PageWords     = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [DramAddrWidth-1:0] cmd_addr_i,
  input  logic [DramLenWidth-1:0]  cmd_len_i,
  input  logic                     cmd_is_write_i,
  input  logic [DramDataWidth-1:0] w_data_i,
  input  logic                     w_data_valid_i,
  output logic                     w_data_ready_o,
  input  logic [MaskWidth-1:0]     write_mask_i,
  output logic [DramDataWidth-1:0] r_data_o,
  output logic                     r_last_o,
  output logic                     r_data_valid_o,
  input  logic                     r_data_ready_i,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [DramAddrWidth-1:0] mem_addr_o,
  output logic [DramDataWidth-1:0] mem_wdata_o,
  output logic [MaskWidth-1:0]     mem_be_o,
  input  logic [DramDataWidth-1:0] mem_rdata_i,
  output logic                     page_err_o
);

  state_e                    state_q;
  state_e                    state_d;
  logic [DramAddrWidth-1:0]  addr_q;
  logic [DramLenWidth-1:0]   cnt_q;
  logic [MemReadLatency-1:0] infl_q;
  logic [MemReadLatency-1:0] infl_last_q;
  logic                      cmd_fire;
  logic                      wr_fire;
  logic                      rd_issue;
  logic                      last_beat;
  logic                      pop;
  logic [1:0]                fifo_cnt;
  logic [2:0]                rd_occ;

  assign cmd_fire  = cmd_valid_i & cmd_ready_o;
  assign last_beat = (cnt_q == '0);
  // Buffered plus in-flight words must never exceed the FIFO depth.
  assign rd_occ    = {1'b0, fifo_cnt} + 3'($countones(infl_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      infl_q      <= '0;
      infl_last_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        addr_q <= cmd_addr_i;
        cnt_q  <= cmd_len_i;
      end else if (wr_fire || rd_issue) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
      infl_q[0]      <= rd_issue;
      infl_last_q[0] <= rd_issue & last_beat;
      for (int i = 1; i < MemReadLatency; i++) begin
        infl_q[i]      <= infl_q[i-1];
        infl_last_q[i] <= infl_last_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) state_d = cmd_is_write_i ? WRITE : READ;
      end
      WRITE: begin
        if (wr_fire && last_beat) state_d = IDLE;
      end
      READ: begin
        if (rd_issue && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o    = (state_q == IDLE);
    w_data_ready_o = (state_q == WRITE);
    wr_fire        = w_data_ready_o & w_data_valid_i;
    rd_issue       = (state_q == READ) &&
                     (rd_occ < 3'(ReadFifoDepth));
    mem_req_o      = wr_fire | rd_issue;
    mem_we_o       = wr_fire;
    mem_addr_o     = mem_req_o ? addr_q : '0;
    mem_wdata_o    = wr_fire ? w_data_i : '0;
    mem_be_o       = wr_fire ? ~write_mask_i : '0;
  end

  assign pop = r_data_valid_o & r_data_ready_i;

  rpc_resp_rd_fifo #(
    .Width(DramDataWidth)
  ) u_rd_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (infl_q[MemReadLatency-1]),
    .push_data_i (mem_rdata_i),
    .push_last_i (infl_last_q[MemReadLatency-1]),
    .pop_i       (pop),
    .valid_o     (r_data_valid_o),
    .data_o      (r_data_o),
    .last_o      (r_last_o),
    .count_o     (fifo_cnt)
  );

`ifdef RPC_RESP_PAGE_CHECK_EN
  localparam int PageBits = $clog2(PageWords);

  logic        page_err_q;
  logic [31:0] page_end;

  assign page_end = 32'(cmd_addr_i[PageBits-1:0]) + 32'(cmd_len_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      page_err_q <= 1'b0;
    end else if (cmd_fire && page_end >= 32'(PageWords)) begin
      page_err_q <= 1'b1;
    end
  end

  assign page_err_o = page_err_q;
`else
  // Folds to constant 0 for any legal (power of two) PageWords.
  assign page_err_o = (PageWords < 1);
`endif

endmodule

// File: tb/tb_rpc_cmd_responder.sv
// Directed self-checking bench for rpc_cmd_responder.
// Page-flag expectations follow RPC_RESP_PAGE_CHECK_EN.
module tb_rpc_cmd_responder;

  localparam int AW = 20;
  localparam int LW = 6;
  localparam int DW = 256;
  localparam int MW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_is_write = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [MW-1:0] w_mask = '0;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          r_valid;
  logic          r_ready = 1'b1;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          page_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rd_reqs = 0;
  logic page_exp;

  logic [DW-1:0] sram [256];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [MW-1:0] wr_be_q [$];
  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  int            rx_cyc [$];

  rpc_cmd_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_addr_i     (cmd_addr),
    .cmd_len_i      (cmd_len),
    .cmd_is_write_i (cmd_is_write),
    .w_data_i       (w_data),
    .w_data_valid_i (w_valid),
    .w_data_ready_o (w_ready),
    .write_mask_i   (w_mask),
    .r_data_o       (r_data),
    .r_last_o       (r_last),
    .r_data_valid_o (r_valid),
    .r_data_ready_i (r_ready),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_be_o       (mem_be),
    .mem_rdata_i    (mem_rdata),
    .page_err_o     (page_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old_w,
    input logic [DW-1:0] new_w,
    input logic [MW-1:0] be
  );
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < MW; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // SRAM model: one-cycle registered read, byte-enabled write.
  always @(posedge clk) begin
    if (mem_req && mem_we)
      sram[mem_addr[7:0]] <= merge(sram[mem_addr[7:0]], mem_wdata, mem_be);
    if (mem_req && !mem_we)
      mem_rdata <= sram[mem_addr[7:0]];
  end

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (mem_req && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_be_q.push_back(mem_be);
    end
    if (mem_req && !mem_we) rd_reqs++;
    if (r_valid && r_ready) begin
      rx_data.push_back(r_data);
      rx_last.push_back(r_last);
      rx_cyc.push_back(cyc);
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_be_q.delete();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    rd_reqs = 0;
  endtask

  // Returns at the negedge of the cycle after the accept edge.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic w);
    int n;
    n = 0;
    @(negedge clk);
    cmd_addr = a;
    cmd_len = l;
    cmd_is_write = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [DW-1:0] d0, input logic [MW-1:0] m);
    send_cmd(a, l, 1'b1);
    for (int i = 0; i <= int'(l); i++) begin
      chk("w_ready", w_ready, 1'b1);
      w_valid = 1'b1;
      w_data = d0 + DW'(i);
      w_mask = m;
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_mask = '0;
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_data.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", rx_data.size(), n);
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    r_ready = 1'b1;
    send_cmd(a, l, 1'b0);
    wait_rx(int'(l) + 1);
  endtask

  initial begin
    int n;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_w;
`ifdef RPC_RESP_PAGE_CHECK_EN
    page_exp = 1'b1;
`else
    page_exp = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_page_err", page_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 4-beat write then read-back
    clear_logs();
    write_burst(20'h00010, 6'd3, 256'hA0, '0);
    chk("wr4_count", wr_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr4_addr", wr_addr_q[i], 20'h00010 + 20'(i));
      chk("wr4_data", wr_data_q[i], 256'hA0 + DW'(i));
      chk("wr4_be", wr_be_q[i], 32'hFFFF_FFFF);
    end
    read_burst(20'h00010, 6'd3);
    for (int i = 0; i < 4; i++) begin
      chk("rd4_data", rx_data[i], 256'hA0 + DW'(i));
      chk("rd4_last", rx_last[i], (i == 3));
    end
    chk("rd4_latency", rx_cyc[0] - acc_cyc, 2);
    chk("rd4_rate", rx_cyc[3] - rx_cyc[0], 3);

    // byte mask over all-ones
    clear_logs();
    d = {8{32'h1122_3344}};
    write_burst(20'h00020, 6'd0, '1, '0);
    write_burst(20'h00020, 6'd0, d, 32'h0000_000F);
    chk("mask_be", wr_be_q[1], 32'hFFFF_FFF0);
    exp_w = {d[255:32], 32'hFFFF_FFFF};
    read_burst(20'h00020, 6'd0);
    chk("mask_data", rx_data[0], exp_w);
    chk("mask_last", rx_last[0], 1'b1);

    // 8-beat read under backpressure
    write_burst(20'h00040, 6'd7, 256'hB0, '0);
    clear_logs();
    r_ready = 1'b0;
    send_cmd(20'h00040, 6'd7, 1'b0);
    n = 0;
    while (!r_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", r_valid, 1'b1);
    repeat (5) @(negedge clk);
    chk("stall_rd_reqs", rd_reqs, 2);
    chk("stall_head", r_data, 256'hB0);
    chk("stall_rx", rx_data.size(), 0);
    r_ready = 1'b1;
    wait_rx(8);
    for (int i = 0; i < 8; i++) begin
      chk("stall_data", rx_data[i], 256'hB0 + DW'(i));
      chk("stall_last", rx_last[i], (i == 7));
    end
    chk("stall_rd_total", rd_reqs, 8);

    // page flag: in-page then crossing command
    read_burst(20'h0003C, 6'd3);
    chk("page_in", page_err, 1'b0);
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    send_cmd(20'h0003E, 6'd3, 1'b0);
    chk("page_cross", page_err, page_exp);
    wait_rx(4);
    repeat (3) @(negedge clk);
    chk("page_sticky", page_err, page_exp);

    // address wrap
    clear_logs();
    write_burst(20'hFFFFF, 6'd1, 256'hC0, '0);
    chk("wrap_addr0", wr_addr_q[0], 20'hFFFFF);
    chk("wrap_addr1", wr_addr_q[1], 20'h00000);
    read_burst(20'hFFFFF, 6'd1);
    chk("wrap_rd0", rx_data[0], 256'hC0);
    chk("wrap_rd1", rx_data[1], 256'hC1);

    // reset in the middle of a write burst
    clear_logs();
    send_cmd(20'h00050, 6'd3, 1'b1);
    w_valid = 1'b1;
    w_data = 256'hD0;
    @(negedge clk);
    w_data = 256'hD1;
    @(negedge clk);
    w_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_w_ready", w_ready, 1'b0);
    chk("mid_rst_mem_req", mem_req, 1'b0);
    chk("mid_rst_page_err", page_err, 1'b0);
    chk("mid_rst_writes", wr_addr_q.size(), 2);
    @(negedge clk);
    rst = 1'b0;
    read_burst(20'h00050, 6'd1);
    chk("post_rst_rd0", rx_data[0], 256'hD0);
    chk("post_rst_rd1", rx_data[1], 256'hD1);
    chk("post_rst_last", rx_last[1], 1'b1);
    chk("post_rst_writes", wr_addr_q.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rpc_cmd_responder.md
Name: rpc_cmd_responder

Overview:
Device-side end of the controller command/PHY interface. It accepts commands (addr, len, is_write) and write words with byte masks, executes them against a single-port, fixed-latency SRAM, and returns read words with a last flag. Two uses: FPGA emulation without an RPC DRAM die, and a synthesizable responder behind the controller interface in system tests.

Parameters:
DramAddrWidth, 20, word address width (one word = DramDataWidth bits)
DramLenWidth, 6, burst length field width; beats = len+1
DramDataWidth, 256, data word width
MaskWidth, 32, DramDataWidth/8; one bit per byte
PageWords, 64, words per DRAM page; power of two; used only by optional check

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_addr_i  in  DramAddrWidth  start word address
cmd_len_i  in  DramLenWidth  beats minus one
cmd_is_write_i  in  1  1 = write, 0 = read
w_data_i  in  DramDataWidth  write word
w_data_valid_i  in  1  write word valid
w_data_ready_o  out  1  write word ready
write_mask_i  in  MaskWidth  1 = byte NOT written; qualified by w_data_valid_i
r_data_o  out  DramDataWidth  read word
r_last_o  out  1  last beat of read burst
r_data_valid_o  out  1  read word valid
r_data_ready_i  in  1  read word ready
mem_req_o  out  1  SRAM access strobe
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  DramAddrWidth  SRAM word address
mem_wdata_o  out  DramDataWidth  SRAM write data
mem_be_o  out  MaskWidth  SRAM byte enable = ~write_mask_i
mem_rdata_i  in  DramDataWidth  SRAM read data, valid exactly 1 cycle after a read mem_req_o
page_err_o  out  1  sticky page-crossing error (optional feature)

Behaviour:
- Reset (async assert, sync release): FSM = IDLE; counters, FIFO, in-flight flag, page_err_o cleared. All outputs 0 except cmd_ready_o = 1. An in-flight SRAM read is dropped; a partial burst is abandoned.
- FSM states IDLE, WRITE, READ. cmd_ready_o = (state == IDLE).
- IDLE: on cmd_valid_i & cmd_ready_o, latch addr into addr_q and len into beat counter cnt_q; go to WRITE or READ per cmd_is_write_i.
- WRITE: w_data_ready_o = 1. Each w_data_valid_i beat drives, combinationally in the same cycle: mem_req_o = 1, mem_we_o = 1, mem_addr_o = addr_q, mem_wdata_o = w_data_i, mem_be_o = ~write_mask_i. Then addr_q += 1 and cnt_q -= 1. On the beat with cnt_q == 0, go to IDLE. In other states w_data_ready_o = 0 and write data is ignored.
- READ: issue a read (mem_req_o = 1, mem_we_o = 0) only when FIFO occupancy + in-flight < 2. The in-flight flag sets on issue and clears the next cycle. Returned data is pushed into a 2-entry FIFO with its last tag (cnt_q == 0 at issue). After the last issue, go to IDLE. FIFO drain may overlap a following command.
- Read output: r_data_valid_o = FIFO non-empty. r_data_o and r_last_o come from the FIFO head. Pop on r_data_valid_o & r_data_ready_i. Push and pop in the same cycle are legal.
- Latency: command accepted in cycle N; first SRAM access in N+1. First read word valid at N+2 when unstalled. Sustained throughput is 1 beat/cycle for both directions with no backpressure.
- addr_q wraps modulo 2^DramAddrWidth.
- len = 2^DramLenWidth-1 gives the maximum burst of 2^DramLenWidth beats.
- Ordering: a write following a read drains correctly because all reads were issued before IDLE. Returned data always matches issue order.
- No two mem_req_o in one cycle. mem_req_o = 0 in IDLE.

Optional Feature:
RPC_RESP_PAGE_CHECK_EN.
- Defined: on command accept, if (cmd_addr_i mod PageWords) + cmd_len_i >= PageWords, set page_err_o. It stays set until reset. The command still executes normally.
- Not defined: page_err_o tied to 0 and no check logic is synthesized.

Decomposition:
- Shared package rpc_resp_pkg holds:
  - state enum (IDLE, WRITE, READ)
  - localparam ReadFifoDepth = 2
  - localparam MemReadLatency = 1
- Sub-module rpc_resp_rd_fifo: 2-entry FIFO of {data, last}, using the same active-high async reset.

Test Plan:
- Write 4 beats (len=3) at addr 0x00010 with data 0xA0..0xA3 and mask all-0 -> 4 mem writes at 0x10..0x13 with be all-1. Then read len=3 at 0x10 -> r_data 0xA0..0xA3, r_last only on the 4th beat, first valid 2 cycles after the command handshake.
- Write 1 beat at 0x20, mask 0x0000_000F, over prior data of all-F -> mem_be_o = 0xFFFF_FFF0. Read-back shows bytes 0..3 unchanged (0xFF) and the rest updated.
- Read len=7 with r_data_ready_i low for 5 cycles after the first valid -> no more than 2 buffered words, no mem read issued while FIFO is full, all 8 words delivered in order without loss.
- Write len=1 at 0xFFFFF -> writes hit 0xFFFFF then 0x00000.
- With RPC_RESP_PAGE_CHECK_EN and PageWords=64: command at addr 0x3E, len=3 -> page_err_o rises the cycle after accept and stays high. The same command at 0x3C leaves it low.
- Assert rst_i after 2 of 4 write beats -> outputs reset immediately, cmd_ready_o = 1, w_data_ready_o = 0, and a new read command executes cleanly.
